// File: rtl/aes_inv_mixcol_unit.sv
// AES InvMixColumns unit: transforms a 128-bit state column group by column group,
// with ready/valid handshakes on both sides and a bypass for the final decrypt round.
module aes_inv_mixcol_unit #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned NCOLS    = 4;
    localparam int unsigned GROUPS   = NCOLS / COLS_PER_CYCLE;
    localparam logic [1:0]  COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0]  LAST_COL = 2'(NCOLS - COLS_PER_CYCLE);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("aes_inv_mixcol_unit: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state_q;
    logic [1:0]     col_q;
    logic           bypass_q;
    logic           ready_en_q;
    logic [127:0]   work_q;
    logic [127:0]   calc_state;
    logic [127:0]   load_state;
    logic           in_fire;

    // Multiply by x in GF(2^8) mod 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One output byte: 0E*a0 ^ 0B*a1 ^ 0D*a2 ^ 09*a3, built from x2/x4/x8 chains.
    function automatic logic [7:0] inv_byte(input logic [7:0] a0, input logic [7:0] a1,
                                            input logic [7:0] a2, input logic [7:0] a3);
        logic [7:0] x2_0, x4_0, x8_0;
        logic [7:0] x2_1, x4_1, x8_1;
        logic [7:0] x2_2, x4_2, x8_2;
        logic [7:0] x4_3, x8_3;
        x2_0 = xtime(a0);
        x4_0 = xtime(x2_0);
        x8_0 = xtime(x4_0);
        x2_1 = xtime(a1);
        x4_1 = xtime(x2_1);
        x8_1 = xtime(x4_1);
        x2_2 = xtime(a2);
        x4_2 = xtime(x2_2);
        x8_2 = xtime(x4_2);
        x4_3 = xtime(xtime(a3));
        x8_3 = xtime(x4_3);
        return (x8_0 ^ x4_0 ^ x2_0)
             ^ (x8_1 ^ x2_1 ^ a1)
             ^ (x8_2 ^ x4_2 ^ a2)
             ^ (x8_3 ^ a3);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {inv_byte(a0, a1, a2, a3), inv_byte(a1, a2, a3, a0),
                inv_byte(a2, a3, a0, a1), inv_byte(a3, a0, a1, a2)};
    endfunction

    function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
        logic [31:0] v;
        case (c)
            2'd0:    v = s[127:96];
            2'd1:    v = s[95:64];
            2'd2:    v = s[63:32];
            default: v = s[31:0];
        endcase
        return v;
    endfunction

    function automatic logic [127:0] put_col(input logic [127:0] s, input logic [1:0] c,
                                             input logic [31:0] v);
        logic [127:0] r;
        r = s;
        case (c)
            2'd0:    r[127:96] = v;
            2'd1:    r[95:64]  = v;
            2'd2:    r[63:32]  = v;
            default: r[31:0]   = v;
        endcase
        return r;
    endfunction

    // Transform the COLS_PER_CYCLE columns starting at base, leaving the rest untouched.
    function automatic logic [127:0] xform_group(input logic [127:0] s, input logic [1:0] base);
        logic [127:0] r;
        logic [1:0]   c;
        r = s;
        for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
            c = base + 2'(g);
            r = put_col(r, c, inv_mix_col(get_col(s, c)));
        end
        return r;
    endfunction

    always_comb begin
        calc_state = xform_group(work_q, col_q);
        load_state = xform_group(in_state, 2'd0);
    end

    // ready_en_q keeps in_ready low during reset and through the first edge after it.
    assign in_ready  = ready_en_q & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
    assign in_fire   = in_valid & in_ready;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_state = work_q;

    // The capture edge also transforms column group 0, so a state spends 4/COLS_PER_CYCLE
    // edges in flight and back-to-back transfers sustain one state per 4/COLS_PER_CYCLE cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            col_q      <= 2'd0;
            bypass_q   <= 1'b0;
            ready_en_q <= 1'b0;
            work_q     <= 128'h0;
        end else begin
            ready_en_q <= 1'b1;
            if (in_fire) begin
                bypass_q <= in_bypass;
                if (in_bypass) begin
                    work_q  <= in_state;
                    col_q   <= 2'd0;
                    state_q <= HOLD;
                end else begin
                    work_q  <= load_state;
                    col_q   <= COL_STEP;
                    state_q <= (GROUPS == 1) ? HOLD : CALC;
                end
            end else begin
                case (state_q)
                    CALC: begin
                        if (bypass_q) begin
                            state_q <= HOLD;
                        end else begin
                            work_q <= calc_state;
                            if (col_q == LAST_COL) begin
                                state_q <= HOLD;
                            end else begin
                                col_q <= col_q + COL_STEP;
                            end
                        end
                    end
                    HOLD: begin
                        if (out_ready) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_inv_mixcol_unit.sv
// Bench for aes_inv_mixcol_unit: one instance per COLS_PER_CYCLE value (1, 2, 4),
// directed steps followed by randomized handshake traffic against a GF(2^8) matrix model.
module tb_aes_inv_mixcol_unit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [2:0]   in_bypass;
    logic [2:0]   out_valid;
    logic [2:0]   out_ready;
    logic [2:0]   busy;
    logic [127:0] in_state  [3];
    logic [127:0] out_state [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        aes_inv_mixcol_unit #(.COLS_PER_CYCLE(1 << k)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[k]),
            .in_ready  (in_ready[k]),
            .in_state  (in_state[k]),
            .in_bypass (in_bypass[k]),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .out_state (out_state[k]),
            .busy      (busy[k])
        );
    end

    // Shift-and-add GF(2^8) product, reduced by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h11B << (i - 8);
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] s, input logic byp);
        logic [7:0]   coef [4];
        logic [7:0]   a    [4];
        logic [7:0]   bb;
        logic [127:0] r;
        if (byp) return s;
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) a[rr] = s[127 - 32*c - 8*rr -: 8];
            for (int rr = 0; rr < 4; rr++) begin
                bb = '0;
                for (int j = 0; j < 4; j++) bb ^= gmul(coef[j], a[(rr + j) % 4]);
                r[127 - 32*c - 8*rr -: 8] = bb;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        in_valid  = '0;
        in_bypass = '0;
        out_ready = '0;
        for (int k = 0; k < 3; k++) in_state[k] = '0;
    endtask

    // Transfer one state into DUT k and count edges (transfer edge included) until out_valid.
    task automatic send_wait(input int k, input logic [127:0] s, input logic b, output int lat);
        @(negedge clk);
        in_valid[k]  = 1'b1;
        in_state[k]  = s;
        in_bypass[k] = b;
        out_ready[k] = 1'b0;
        #1;
        check("ready_before_send", 128'(in_ready[k]), 128'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        lat = 1;
        while (!out_valid[k] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop(input int k);
        @(negedge clk);
        out_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[k] = 1'b0;
        check("valid_after_pop", 128'(out_valid[k]), 128'd0);
        check("busy_after_pop", 128'(busy[k]), 128'd0);
    endtask

    task automatic run_random(input int k, input int n);
        logic [127:0] q[$];
        int sent, recv, cyc;
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < n && cyc < 30000) begin
            @(negedge clk);
            in_valid[k]  = (sent < n) && ($urandom_range(3) != 0);
            in_state[k]  = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_bypass[k] = 1'($urandom_range(1));
            out_ready[k] = ($urandom_range(3) != 0);
            #1;
            if (out_valid[k] && out_ready[k]) begin
                check("rand_queue_nonempty", 128'(q.size() != 0), 128'd1);
                if (q.size() != 0) check("rand_data", out_state[k], q.pop_front());
                recv++;
            end
            if (in_valid[k] && in_ready[k]) begin
                q.push_back(ref_model(in_state[k], in_bypass[k]));
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
        check("rand_recv_count", 128'(recv), 128'(n));
        check("rand_queue_empty", 128'(q.size()), 128'd0);
        repeat (6) @(negedge clk);
        check("rand_no_extra_out", 128'(out_valid[k]), 128'd0);
    endtask

    initial begin
        logic [127:0] vec_in, vec_out, pass_vec, x_vec, exp_x;
        logic [127:0] q4[$];
        int lat, outs, first_out, last_out;

        vec_in   = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
        vec_out  = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
        pass_vec = 128'h00112233_44556677_8899aabb_ccddeeff;

        // Reset values
        rst_n = 1'b0;
        idle_all();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_in_ready", 128'(in_ready[k]), 128'd0);
            check("rst_out_valid", 128'(out_valid[k]), 128'd0);
            check("rst_busy", 128'(busy[k]), 128'd0);
            check("rst_out_state", out_state[k], 128'h0);
        end
        rst_n = 1'b1;
        #1;
        check("ready_before_first_edge", 128'(in_ready[0]), 128'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check("ready_after_first_edge", 128'(in_ready[k]), 128'd1);

        // Known vector on every width, latency 4/COLS_PER_CYCLE
        for (int k = 0; k < 3; k++) begin
            send_wait(k, vec_in, 1'b0, lat);
            check("vec_latency", 128'(lat), 128'(4 >> k));
            check("vec_out_state", out_state[k], vec_out);
            pop(k);
        end

        // Bypass: one cycle, unchanged
        send_wait(0, pass_vec, 1'b1, lat);
        check("bypass_latency", 128'(lat), 128'd1);
        check("bypass_out_state", out_state[0], pass_vec);

        // Backpressure in HOLD with a pending input
        x_vec = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp_x = ref_model(x_vec, 1'b0);
        @(negedge clk);
        in_valid[0]  = 1'b1;
        in_state[0]  = x_vec;
        in_bypass[0] = 1'b0;
        out_ready[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("stall_in_ready", 128'(in_ready[0]), 128'd0);
            check("stall_out_valid", 128'(out_valid[0]), 128'd1);
            check("stall_out_state", out_state[0], pass_vec);
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        #1;
        check("release_in_ready", 128'(in_ready[0]), 128'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        check("release_busy", 128'(busy[0]), 128'd1);
        check("release_out_valid", 128'(out_valid[0]), 128'd0);
        lat = 1;
        while (!out_valid[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("release_latency", 128'(lat), 128'd4);
        check("release_out_state", out_state[0], exp_x);
        pop(0);

        // COLS_PER_CYCLE=4: 8 back-to-back inputs give 8 consecutive outputs
        outs      = 0;
        first_out = -1;
        last_out  = -1;
        begin
            int pushed;
            pushed = 0;
            for (int cyc = 0; cyc < 20; cyc++) begin
                @(negedge clk);
                out_ready[2] = 1'b1;
                in_valid[2]  = (pushed < 8);
                in_bypass[2] = 1'b0;
                in_state[2]  = {$urandom(), $urandom(), $urandom(), $urandom()};
                #1;
                if (out_valid[2]) begin
                    if (q4.size() != 0) check("b2b_data", out_state[2], q4.pop_front());
                    outs++;
                    if (first_out < 0) first_out = cyc;
                    last_out = cyc;
                end
                if (in_valid[2] && in_ready[2]) begin
                    q4.push_back(ref_model(in_state[2], 1'b0));
                    pushed++;
                end
            end
        end
        @(negedge clk);
        in_valid[2]  = 1'b0;
        out_ready[2] = 1'b0;
        check("b2b_out_count", 128'(outs), 128'd8);
        check("b2b_consecutive", 128'(last_out - first_out), 128'd7);

        // Reset while the COLS_PER_CYCLE=1 unit sits at col=2
        @(negedge clk);
        in_valid[0]  = 1'b1;
        in_state[0]  = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_bypass[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(out_valid[0]), 128'd0);
        check("midrst_out_state", out_state[0], 128'h0);
        check("midrst_busy", 128'(busy[0]), 128'd0);
        check("midrst_in_ready", 128'(in_ready[0]), 128'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_output", 128'(out_valid[0]), 128'd0);
        x_vec = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_wait(0, x_vec, 1'b0, lat);
        check("postrst_latency", 128'(lat), 128'd4);
        check("postrst_out_state", out_state[0], ref_model(x_vec, 1'b0));
        pop(0);

        // Randomized traffic on every width
        for (int k = 0; k < 3; k++) run_random(k, 3400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
